gray_seq_checker: RTL and testbench

Downstream consumer of the gray-code counter output. Samples a W-bit gray code each cycle it is marked valid and converts it to binary with one cycle of registered latency. Checks that each new code is the legal successor of the previous one: +1 modulo 2^W, optionally allowing a hold. Reports wrap-around, illegal steps and a saturating error count, so counter integrity can be monitored in-system and by the bench.

---
 rtl/gray_seq_chk_pkg.sv | 21 ++
 rtl/gray_to_bin.sv | 13 +
 rtl/gray_seq_checker.sv | 112 +++++++++++
 tb/tb_gray_seq_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/gray_seq_chk_pkg.sv
// Shared types and the successor check for the gray-code sequence checker.
package gray_seq_chk_pkg;

    localparam int unsigned MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    // True when n equals p+1 modulo 2^w. p and n are zero-extended to MAX_W.
    function automatic logic is_successor(input logic [MAX_W-1:0] p,
                                          input logic [MAX_W-1:0] n,
                                          input int unsigned      w);
        logic [MAX_W:0] nxt;
        nxt = ({1'b0, p} + 17'd1) & ((17'd1 << w) - 17'd1);
        return nxt == {1'b0, n};
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary decode: each binary bit is the XOR of all gray bits at or above it.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/gray_seq_checker.sv
// Samples gray codes, decodes them with one cycle of latency and flags any step that is not +1 (or a hold).
// Optional 16-bit wrap counter is built when GRAY_SEQ_CHK_WRAP_CNT_EN is defined.
module gray_seq_checker
    import gray_seq_chk_pkg::*;
#(
    parameter int W          = 4,
    parameter int ALLOW_HOLD = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [W-1:0]         gray_in,
    input  logic                 in_valid,
    input  logic                 clear,
    output logic [W-1:0]         bin_out,
    output logic                 out_valid,
    output logic                 wrap_pulse,
    output logic                 step_err,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
    output logic [15:0]          wrap_count,
`endif
    output state_t               dbg_state
);

    // Handshake: in_valid qualifies gray_in for one cycle; there is no ready, every valid cycle is
    // accepted unless clear is high in the same cycle, in which case the sample is dropped.

    logic [W-1:0]         bin_dec;
    state_t               state_q;
    logic [W-1:0]         bin_q;
    logic                 out_valid_q;
    logic                 wrap_q;
    logic                 step_err_q;
    logic                 err_flag_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 legal;
    logic                 is_wrap;

    gray_to_bin #(.W(W)) u_dec (
        .gray_i (gray_in),
        .bin_o  (bin_dec)
    );

    // bin_q doubles as the reference: in TRACK it always holds the last accepted code.
    always_comb begin
        legal   = is_successor(MAX_W'(bin_q), MAX_W'(bin_dec), W)
                  || ((ALLOW_HOLD != 0) && (bin_dec == bin_q));
        is_wrap = (bin_q == '1) && (bin_dec == '0);
    end

`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
    logic [15:0] wrap_cnt_q;
    assign wrap_count = wrap_cnt_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            step_err_q  <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cnt_q   <= '0;
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
            wrap_cnt_q  <= '0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            step_err_q  <= 1'b0;
            if (clear) begin
                state_q    <= IDLE;
                err_flag_q <= 1'b0;
            end else if (in_valid) begin
                bin_q       <= bin_dec;
                out_valid_q <= 1'b1;
                case (state_q)
                    IDLE: state_q <= TRACK;
                    TRACK: begin
                        if (legal) begin
                            if (is_wrap) begin
                                wrap_q <= 1'b1;
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
                                if (wrap_cnt_q != 16'hFFFF) wrap_cnt_q <= wrap_cnt_q + 16'd1;
`endif
                            end
                        end else begin
                            step_err_q <= 1'b1;
                            err_flag_q <= 1'b1;
                            state_q    <= ERROR;
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                        end
                    end
                    ERROR:   state_q <= ERROR;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bin_out    = bin_q;
    assign out_valid  = out_valid_q;
    assign wrap_pulse = wrap_q;
    assign step_err   = step_err_q;
    assign err_flag   = err_flag_q;
    assign err_count  = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed bench for gray_seq_checker: vector table plus hand sequences for saturation, async reset and hold.
module tb_gray_seq_checker;
    import gray_seq_chk_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] gray_in = '0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;

    logic [3:0] bin_out, bin_out_nh;
    logic       out_valid, wrap_pulse, step_err, err_flag;
    logic       out_valid_nh, wrap_pulse_nh, step_err_nh, err_flag_nh;
    logic [7:0] err_count, err_count_nh;
    state_t     dbg_state, dbg_state_nh;
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
    logic [15:0] wrap_count, wrap_count_nh;
`endif

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    gray_seq_checker #(.W(4), .ALLOW_HOLD(1), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .reset_n(reset_n), .gray_in(gray_in), .in_valid(in_valid), .clear(clear),
        .bin_out(bin_out), .out_valid(out_valid), .wrap_pulse(wrap_pulse), .step_err(step_err),
        .err_flag(err_flag), .err_count(err_count),
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
        .wrap_count(wrap_count),
`endif
        .dbg_state(dbg_state)
    );

    gray_seq_checker #(.W(4), .ALLOW_HOLD(0), .ERR_CNT_W(8)) u_dut_nh (
        .clk(clk), .reset_n(reset_n), .gray_in(gray_in), .in_valid(in_valid), .clear(clear),
        .bin_out(bin_out_nh), .out_valid(out_valid_nh), .wrap_pulse(wrap_pulse_nh),
        .step_err(step_err_nh), .err_flag(err_flag_nh), .err_count(err_count_nh),
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
        .wrap_count(wrap_count_nh),
`endif
        .dbg_state(dbg_state_nh)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [3:0] g;
        logic       ov;
        logic [3:0] bin;
        logic       wrap;
        logic       step;
        logic       flag;
        logic [7:0] cnt;
        state_t     st;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_step(input logic c, input logic v, input logic [3:0] g);
        clear    = c;
        in_valid = v;
        gray_in  = g;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic c, input logic v, input logic [3:0] g, input logic ov,
                                input logic [3:0] b, input logic w, input logic s, input logic f,
                                input logic [7:0] n, input state_t st);
        vec_t r;
        r.clr = c; r.vld = v; r.g = g; r.ov = ov; r.bin = b;
        r.wrap = w; r.step = s; r.flag = f; r.cnt = n; r.st = st;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            logic [3:0] b;
            b = 4'(i);
            vecs[i] = mk(0, 1, b ^ (b >> 1), 1, b, 0, 0, 0, 8'd0, TRACK);
        end
        vecs[16] = mk(0, 1, 4'b0000, 1, 4'd0,  1, 0, 0, 8'd0, TRACK);
        vecs[17] = mk(0, 0, 4'b1010, 0, 4'd0,  0, 0, 0, 8'd0, TRACK);
        vecs[18] = mk(0, 1, 4'b0001, 1, 4'd1,  0, 0, 0, 8'd0, TRACK);
        vecs[19] = mk(0, 1, 4'b0001, 1, 4'd1,  0, 0, 0, 8'd0, TRACK);
        vecs[20] = mk(0, 1, 4'b0010, 1, 4'd3,  0, 1, 1, 8'd1, ERROR);
        vecs[21] = mk(0, 1, 4'b0110, 1, 4'd4,  0, 0, 1, 8'd1, ERROR);
        vecs[22] = mk(0, 1, 4'b1111, 1, 4'd10, 0, 0, 1, 8'd1, ERROR);
        vecs[23] = mk(0, 0, 4'b0000, 0, 4'd10, 0, 0, 1, 8'd1, ERROR);
        vecs[24] = mk(1, 0, 4'b0000, 0, 4'd10, 0, 0, 0, 8'd1, IDLE);
        vecs[25] = mk(1, 1, 4'b0110, 0, 4'd10, 0, 0, 0, 8'd1, IDLE);
        vecs[26] = mk(0, 1, 4'b1111, 1, 4'd10, 0, 0, 0, 8'd1, TRACK);
        vecs[27] = mk(0, 1, 4'b1110, 1, 4'd11, 0, 0, 0, 8'd1, TRACK);
        vecs[28] = mk(0, 1, 4'b1000, 1, 4'd15, 0, 1, 1, 8'd2, ERROR);

        // Reset state.
        #12;
        chk("rst_bin", 32'(bin_out), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_flag", 32'(err_flag), 0);
        chk("rst_cnt", 32'(err_count), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 29; i++) begin
            drive_step(vecs[i].clr, vecs[i].vld, vecs[i].g);
            chk($sformatf("v%0d_ov", i),    32'(out_valid),  32'(vecs[i].ov));
            chk($sformatf("v%0d_bin", i),   32'(bin_out),    32'(vecs[i].bin));
            chk($sformatf("v%0d_wrap", i),  32'(wrap_pulse), 32'(vecs[i].wrap));
            chk($sformatf("v%0d_step", i),  32'(step_err),   32'(vecs[i].step));
            chk($sformatf("v%0d_flag", i),  32'(err_flag),   32'(vecs[i].flag));
            chk($sformatf("v%0d_cnt", i),   32'(err_count),  32'(vecs[i].cnt));
            chk($sformatf("v%0d_state", i), 32'(dbg_state),  32'(vecs[i].st));
        end
`ifdef GRAY_SEQ_CHK_WRAP_CNT_EN
        chk("wrap_count", 32'(wrap_count), 1);
`endif

        // Saturation: repeated clear / reference / skip, count must stop at all-ones.
        for (int k = 0; k < 260; k++) begin
            drive_step(1, 0, 4'b0000);
            drive_step(0, 1, 4'b0000);
            drive_step(0, 1, 4'b0010);
            if (k == 252) chk("sat_cnt_255", 32'(err_count), 255);
        end
        chk("sat_step", 32'(step_err), 1);
        chk("sat_cnt", 32'(err_count), 255);

        // Asynchronous reset between edges.
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_bin", 32'(bin_out), 0);
        chk("arst_ov", 32'(out_valid), 0);
        chk("arst_step", 32'(step_err), 0);
        chk("arst_flag", 32'(err_flag), 0);
        chk("arst_cnt", 32'(err_count), 0);
        chk("arst_state", 32'(dbg_state), 32'(IDLE));
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive_step(0, 1, 4'b0101);
        chk("post_rst_bin", 32'(bin_out), 6);
        chk("post_rst_ov", 32'(out_valid), 1);
        chk("post_rst_step", 32'(step_err), 0);
        chk("post_rst_step_nh", 32'(step_err_nh), 0);

        // Hold: legal with ALLOW_HOLD=1, an error with ALLOW_HOLD=0.
        drive_step(0, 1, 4'b0101);
        chk("hold_step", 32'(step_err), 0);
        chk("hold_ov", 32'(out_valid), 1);
        chk("hold_bin", 32'(bin_out), 6);
        chk("hold_step_nh", 32'(step_err_nh), 1);
        chk("hold_flag_nh", 32'(err_flag_nh), 1);
        chk("hold_cnt_nh", 32'(err_count_nh), 1);
        drive_step(0, 0, 4'b0000);
        chk("idle_ov", 32'(out_valid), 0);
        chk("idle_step_nh", 32'(step_err_nh), 0);
        chk("idle_flag_nh", 32'(err_flag_nh), 1);
        chk("idle_bin_nh", 32'(bin_out_nh), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
